button_events: RTL and testbench
================================

# button_events

Converts the debounced level of one controller button into single-cycle event pulses for the game logic: press, release, long-press, auto-repeat and double-press. Sits directly downstream of the pushbutton debouncer; its `clean_in` is that stage's clean output. The menu, dialogue and overworld FSMs consume these pulses, so no consumer does its own edge detection.

## Interface

Parameters:
- `LONG_CYCLES`, default 65_000_000: hold time before `long_out`. This is 1 s at 65 MHz. Must be ≥1.
- `REPEAT_DELAY`, default 32_500_000: hold time before the first `repeat_out`. Must be ≥1.
- `REPEAT_PERIOD`, default 6_500_000: spacing of subsequent `repeat_out` pulses. Must be ≥1.
- `DOUBLE_WINDOW`, default 19_500_000: maximum release-to-press gap, in cycles, that counts as a double press. Must be ≥1.

Ports:
- `clock_in`, input, 1: system clock. Everything is on its rising edge.
- `reset_n_in`, input, 1: asynchronous, active-low reset.
- `clean_in`, input, 1: debounced button level (1 = pressed), already synchronous to `clock_in`.
- `press_out`, output, 1: one-cycle pulse on press.
- `release_out`, output, 1: one-cycle pulse on release.
- `long_out`, output, 1: one-cycle pulse, at most once per hold.
- `repeat_out`, output, 1: one-cycle auto-repeat pulses while held.
- `double_out`, output, 1: one-cycle pulse on the second press of a double press.
- `held_out`, output, 1: registered level, high from the press edge to the release edge.

## Operation

- All outputs are registered.
- Counter width is `$clog2` of the largest parameter plus 1. Counters saturate and never wrap.
- **Reset:** while `reset_n_in`=0, every output is 0, the state is IDLE, all counters are 0, `armed`=0 and `prev`=0.
- **Arm cycle:** the first edge after reset release only loads `prev` from `clean_in` and sets `armed`.
  - No event fires on that edge.
  - A button already held through reset produces no `press_out`; its first event is `release_out`.
- **Edge definitions** (only when `armed`=1):
  - rise = `clean_in` & ~`prev`
  - fall = ~`clean_in` & `prev`
  - `prev` ← `clean_in` on every edge.
- **States:** IDLE, HELD, GAP.
- **IDLE:**
  - On rise: `press_out`=1, `held_out`←1, `hold_cnt`←0, `rep_cnt`←0, go to HELD.
- **HELD:**
  - `hold_cnt` and `rep_cnt` increment each edge.
  - `long_out` pulses on the edge where `hold_cnt`+1 = `LONG_CYCLES`, once only; a `long_done` flag blocks any further pulse.
  - The first `repeat_out` pulses when `rep_cnt`+1 = `REPEAT_DELAY`. After that it pulses every `REPEAT_PERIOD` edges (`rep_cnt` reloads to `REPEAT_DELAY`−`REPEAT_PERIOD`).
  - `long_out` and `repeat_out` may pulse on the same edge.
  - On fall: `release_out`=1, `held_out`←0, `gap_cnt`←0, `long_done`←0, go to GAP. Fall takes priority: an edge that sees fall emits no `long_out` or `repeat_out`.
- **GAP:**
  - `gap_cnt` increments each edge.
  - Rise with `gap_cnt` < `DOUBLE_WINDOW`: `press_out`=1 and `double_out`=1 on the same edge, go to HELD.
  - When `gap_cnt` reaches `DOUBLE_WINDOW` with no rise, go to IDLE.
  - A rise after that is a plain press.
- A double press cannot chain. The press that raises `double_out` leads to a GAP after its release that can only produce a plain press, enforced by a `was_double` flag.
- Asserting reset mid-hold or mid-gap aborts immediately. No pulse is emitted for the aborted operation.

## Timing

- Let edge k be the first armed edge that sees `clean_in`=1 with `prev`=0.
  - `press_out` is high for exactly the cycle after edge k. Latency is 1 cycle from the sampled input.
- `long_out` fires at edge k+`LONG_CYCLES`, provided `clean_in` was sampled 1 on edges k+1 through k+`LONG_CYCLES`.
- `repeat_out` fires at edges k+`REPEAT_DELAY`+n·`REPEAT_PERIOD`, for n ≥ 0.
- Let edge m be the release edge. `release_out` fires at edge m.
  - A press sampled at edge m+j, with 1 ≤ j ≤ `DOUBLE_WINDOW`, is a double press.
- No output is ever high for two consecutive cycles, except `held_out`.

## Test plan

Overrides for the bench: `LONG_CYCLES`=20, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4, `DOUBLE_WINDOW`=10.

1. Hold `clean_in`=1 across reset release. Expect: no `press_out`; `release_out` exactly 1 cycle after the drop is sampled; `held_out` stays 0.
2. Press for 3 cycles. Expect: `press_out` at k, `release_out` at k+3, and no `long_out`, `repeat_out` or `double_out`.
3. Press for 30 cycles. Expect: `repeat_out` at k+8, 12, 16, 20, 24, 28; `long_out` only at k+20, coinciding with a repeat; `release_out` at k+30.
4. Release at exactly k+20. Expect: `release_out` at k+20 and no `long_out` or `repeat_out` on that edge.
5. Press 2 cycles, then gap presses. Expect: a second press 10 cycles after the release edge gives `press_out`+`double_out`; a repeat with an 11-cycle gap gives `press_out` only. A third quick press after the double gives no `double_out`.
6. Drop `reset_n_in` mid-hold at k+5. Expect: all outputs 0 asynchronously. After release there is 1 arm cycle, then behaviour per scenario 1.

Source files
------------

// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press/release/long/repeat/double
// pulses plus a registered held level. All outputs are registered.
module button_events #(
    parameter int LONG_CYCLES   = 65_000_000,
    parameter int REPEAT_DELAY  = 32_500_000,
    parameter int REPEAT_PERIOD = 6_500_000,
    parameter int DOUBLE_WINDOW = 19_500_000
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic clean_in,
    output logic press_out,
    output logic release_out,
    output logic long_out,
    output logic repeat_out,
    output logic double_out,
    output logic held_out
);

    localparam int MAX_A = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
    localparam int MAX_B = (REPEAT_PERIOD > DOUBLE_WINDOW) ? REPEAT_PERIOD : DOUBLE_WINDOW;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LONG_C   = cnt_t'(LONG_CYCLES);
    localparam cnt_t DELAY_C  = cnt_t'(REPEAT_DELAY);
    localparam cnt_t WINDOW_C = cnt_t'(DOUBLE_WINDOW);
    // A period longer than the delay cannot be reloaded below zero; clamp to a full delay.
    localparam cnt_t RELOAD_C = cnt_t'((REPEAT_DELAY > REPEAT_PERIOD) ?
                                       (REPEAT_DELAY - REPEAT_PERIOD) : 0);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic prev_q,       prev_d;
    logic armed_q,      armed_d;
    cnt_t hold_cnt_q,   hold_cnt_d;
    cnt_t rep_cnt_q,    rep_cnt_d;
    cnt_t gap_cnt_q,    gap_cnt_d;
    logic long_done_q,  long_done_d;
    logic was_double_q, was_double_d;
    logic press_q,      press_d;
    logic release_q,    release_d;
    logic long_q,       long_d;
    logic repeat_q,     repeat_d;
    logic double_q,     double_d;
    logic held_q,       held_d;

    logic rise, fall;
    cnt_t hold_inc, rep_inc, gap_inc;
    logic long_hit, rep_hit, gap_open, gap_expired;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : cnt_t'(c + 1'b1);
    endfunction

    assign rise        = armed_q & clean_in & ~prev_q;
    assign fall        = armed_q & ~clean_in & prev_q;
    assign hold_inc    = sat_inc(hold_cnt_q);
    assign rep_inc     = sat_inc(rep_cnt_q);
    assign gap_inc     = sat_inc(gap_cnt_q);
    assign long_hit    = ~long_done_q & (hold_inc == LONG_C);
    assign rep_hit     = (rep_inc == DELAY_C);
    assign gap_open    = (gap_cnt_q < WINDOW_C);
    assign gap_expired = (gap_inc >= WINDOW_C);

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HELD;
            HELD:    if (fall) state_d = GAP;
            GAP: begin
                if (rise)             state_d = HELD;
                else if (gap_expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prev_d       = clean_in;
        armed_d      = 1'b1;
        hold_cnt_d   = hold_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        long_done_d  = long_done_q;
        was_double_d = was_double_q;
        held_d       = held_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        repeat_d     = 1'b0;
        double_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d      = 1'b1;
                    held_d       = 1'b1;
                    hold_cnt_d   = '0;
                    rep_cnt_d    = '0;
                    long_done_d  = 1'b0;
                    was_double_d = 1'b0;
                end else if (fall) begin
                    // Button held through reset: its release is still reported.
                    release_d = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    release_d   = 1'b1;
                    held_d      = 1'b0;
                    gap_cnt_d   = '0;
                    long_done_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_inc;
                    rep_cnt_d  = rep_hit ? RELOAD_C : rep_inc;
                    repeat_d   = rep_hit;
                    if (long_hit) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_inc;
                if (rise) begin
                    press_d      = 1'b1;
                    held_d       = 1'b1;
                    hold_cnt_d   = '0;
                    rep_cnt_d    = '0;
                    long_done_d  = 1'b0;
                    double_d     = gap_open & ~was_double_q;
                    was_double_d = gap_open & ~was_double_q;
                end else if (gap_expired) begin
                    was_double_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            prev_q       <= 1'b0;
            armed_q      <= 1'b0;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            long_done_q  <= 1'b0;
            was_double_q <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            repeat_q     <= 1'b0;
            double_q     <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            armed_q      <= armed_d;
            hold_cnt_q   <= hold_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            long_done_q  <= long_done_d;
            was_double_q <= was_double_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            repeat_q     <= repeat_d;
            double_q     <= double_d;
            held_q       <= held_d;
        end
    end

    assign press_out   = press_q;
    assign release_out = release_q;
    assign long_out    = long_q;
    assign repeat_out  = repeat_q;
    assign double_out  = double_q;
    assign held_out    = held_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: each driven cycle queues the expected
// {press, release, long, repeat, double, held} vector, checked after the next edge.
module tb_button_events;

    localparam int LONG = 20;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int DW   = 10;

    logic clock_in = 1'b0;
    logic reset_n_in;
    logic clean_in;
    logic press_out, release_out, long_out, repeat_out, double_out, held_out;
    logic [5:0] obs;
    logic [5:0] mon_e;
    logic [5:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    string scen = "init";

    button_events #(
        .LONG_CYCLES   (LONG),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .DOUBLE_WINDOW (DW)
    ) dut (
        .clock_in    (clock_in),
        .reset_n_in  (reset_n_in),
        .clean_in    (clean_in),
        .press_out   (press_out),
        .release_out (release_out),
        .long_out    (long_out),
        .repeat_out  (repeat_out),
        .double_out  (double_out),
        .held_out    (held_out)
    );

    always #5 clock_in = ~clock_in;

    assign obs = {press_out, release_out, long_out, repeat_out, double_out, held_out};

    task automatic check_eq(input string tag, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (p r l rp d h) at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] mk(input bit p, input bit r, input bit l,
                                      input bit rp, input bit d, input bit h);
        return {p, r, l, rp, d, h};
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic cin, input logic [5:0] e);
        clean_in = cin;
        exp_q.push_back(e);
        @(negedge clock_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Press for n cycles starting at edge k (j = 0); release edge is j = n.
    task automatic press_hold(input int n, input bit dbl);
        for (int j = 0; j <= n; j++) begin
            step(j < n, mk(j == 0, j == n, (j == LONG) && (j < n),
                           (j >= RD) && (((j - RD) % RP) == 0) && (j < n),
                           dbl && (j == 0), j < n));
        end
    endtask

    // Idle edges between a release edge m and a press sampled at edge m+g.
    task automatic gap(input int g);
        idle(g - 1);
    endtask

    always begin
        @(posedge clock_in);
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq($sformatf("%s@c%0d", scen, cyc), obs, mon_e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_in = 1'b0;
        clean_in   = 1'b1;
        repeat (3) @(negedge clock_in);
        check_eq("in_reset", obs, '0);

        scen = "held_thru_reset";
        reset_n_in = 1'b1;
        repeat (4) step(1'b1, '0);
        step(1'b0, mk(0, 1, 0, 0, 0, 0));
        idle(12);

        scen = "short_press";
        press_hold(3, 1'b0);
        idle(15);

        scen = "long_press";
        press_hold(30, 1'b0);
        idle(15);

        scen = "release_at_long";
        press_hold(20, 1'b0);
        idle(15);

        scen = "double";
        press_hold(2, 1'b0);
        gap(DW);
        press_hold(2, 1'b1);
        gap(3);
        press_hold(2, 1'b0);
        gap(DW + 1);
        press_hold(2, 1'b0);
        gap(DW);
        press_hold(2, 1'b1);
        idle(15);

        scen = "reset_mid_hold";
        for (int j = 0; j < 5; j++) step(1'b1, mk(j == 0, 0, 0, 0, 0, 1));
        check_eq("pre_reset_held", obs, mk(0, 0, 0, 0, 0, 1));
        reset_n_in = 1'b0;
        #1;
        check_eq("async_clear", obs, '0);
        @(negedge clock_in);
        check_eq("reset_hold", obs, '0);
        reset_n_in = 1'b1;
        repeat (3) step(1'b1, '0);
        step(1'b0, mk(0, 1, 0, 0, 0, 0));
        idle(5);

        @(negedge clock_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
